// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit common-anode 7-segment driver for the stopwatch (M.SS.d).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks a zero minutes digit.
module stopwatch_display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:1] decimo,
    input  logic [4:1] uni_segundo,
    input  logic [4:1] dec_segundo,
    input  logic [4:1] minuto,
    output logic [7:1] seg,
    output logic       dp,
    output logic [4:1] an
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_LZ = 1'b1;
`else
    localparam bit BLANK_LZ = 1'b0;
`endif

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [4:1]    snap_dec, snap_uni, snap_dseg, snap_min;
    logic          slot_end;
    logic          in_guard;
    logic [3:0]    digit;
    logic [7:1]    seg_n;
    logic          dp_n;
    logic [4:1]    an_n;

    assign slot_end = (cnt == LAST);

    generate
        if (GUARD == 0) begin : g_noguard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
            assign in_guard = (cnt < GUARD_C);
        end
    endgenerate

    function automatic logic [6:0] bcd7(input logic [3:0] d);
        case (d)
            4'd0:    bcd7 = 7'h40;
            4'd1:    bcd7 = 7'h79;
            4'd2:    bcd7 = 7'h24;
            4'd3:    bcd7 = 7'h30;
            4'd4:    bcd7 = 7'h19;
            4'd5:    bcd7 = 7'h12;
            4'd6:    bcd7 = 7'h02;
            4'd7:    bcd7 = 7'h78;
            4'd8:    bcd7 = 7'h00;
            4'd9:    bcd7 = 7'h10;
            default: bcd7 = 7'h3F;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // All four digits are captured together at the frame boundary so a frame never mixes old and new time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_dec  <= '0;
            snap_uni  <= '0;
            snap_dseg <= '0;
            snap_min  <= '0;
        end else if (slot_end && idx == 2'd3) begin
            snap_dec  <= decimo;
            snap_uni  <= uni_segundo;
            snap_dseg <= dec_segundo;
            snap_min  <= minuto;
        end
    end

    always_comb begin
        digit = '0;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        an_n  = 4'hF;
        case (idx)
            2'd0: digit = snap_dec;
            2'd1: digit = snap_uni;
            2'd2: digit = snap_dseg;
            2'd3: digit = snap_min;
            default: digit = '0;
        endcase
        if (!in_guard) begin
            an_n  = ~(4'b0001 << idx);
            seg_n = bcd7(digit);
            dp_n  = ~idx[0];
            // The anode stays enabled while blanked so every slot keeps the same duty cycle.
            if (BLANK_LZ && idx == 2'd3 && snap_min == 4'd0) begin
                seg_n = 7'h7F;
                dp_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= 4'hF;
        end else begin
            seg <= seg_n;
            dp  <= dp_n;
            an  <= an_n;
        end
    end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Scoreboard bench: a frame-level model of the display pushes expected outputs, compared one cycle later.
// Two instances share stimulus: GUARD=1 and GUARD=2, both SCAN_DIV=4.
module tb_stopwatch_display_scan;

    localparam int SD = 4;
    localparam int FRAME = 4 * SD;
    localparam logic [16*7-1:0] DEC_TAB = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F,
                                           7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19,
                                           7'h30, 7'h24, 7'h79, 7'h40};
    localparam logic [11:0] RESET_OUT = {4'hF, 7'h7F, 1'b1};

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_LZ = 1'b1;
`else
    localparam bit BLANK_LZ = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] g1;
        logic [11:0] g2;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:1] decimo = 4'd3, uni_segundo = 4'd7, dec_segundo = 4'd5, minuto = 4'd2;
    logic [7:1] seg1, seg2;
    logic       dp1, dp2;
    logic [4:1] an1, an2;

    exp_t       sb[$];
    int         t;
    logic [3:0] mdisp [4];
    int         checks = 0;
    int         passes = 0;

    stopwatch_display_scan #(.SCAN_DIV(SD), .GUARD(1)) dut1 (
        .clk(clk), .rst(rst), .decimo(decimo), .uni_segundo(uni_segundo),
        .dec_segundo(dec_segundo), .minuto(minuto), .seg(seg1), .dp(dp1), .an(an1)
    );

    stopwatch_display_scan #(.SCAN_DIV(SD), .GUARD(2)) dut2 (
        .clk(clk), .rst(rst), .decimo(decimo), .uni_segundo(uni_segundo),
        .dec_segundo(dec_segundo), .minuto(minuto), .seg(seg2), .dp(dp2), .an(an2)
    );

    always #5 clk = ~clk;

    // Expected {an, seg, dp} following an edge taken t cycles after reset release.
    function automatic logic [11:0] modelOut(input int guard, input int tt);
        int pos, slot;
        logic [3:0] a;
        logic [6:0] s;
        logic d;
        pos  = tt % SD;
        slot = (tt / SD) % 4;
        if (pos < guard) return RESET_OUT;
        a = 4'hF;
        a[slot] = 1'b0;
        s = DEC_TAB[mdisp[slot]*7 +: 7];
        d = (slot == 1 || slot == 3) ? 1'b0 : 1'b1;
        if (BLANK_LZ && slot == 3 && mdisp[3] == 4'd0) begin
            s = 7'h7F;
            d = 1'b1;
        end
        return {a, s, d};
    endfunction

    task automatic pushExpected();
        exp_t e;
        e.g1 = modelOut(1, t);
        e.g2 = modelOut(2, t);
        sb.push_back(e);
        if (t % FRAME == FRAME - 1) begin
            mdisp[0] = decimo;
            mdisp[1] = uni_segundo;
            mdisp[2] = dec_segundo;
            mdisp[3] = minuto;
        end
        t++;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            $error("[TB] FAIL %s scoreboard empty observed=0 required=1", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert ({an1, seg1, dp1} === e.g1) passes++;
        else $error("[TB] FAIL %s guard1 t=%0d observed an/seg/dp=%b/%h/%b required=%b/%h/%b",
                    tag, t, an1, seg1, dp1, e.g1[11:8], e.g1[7:1], e.g1[0]);
        checks++;
        assert ({an2, seg2, dp2} === e.g2) passes++;
        else $error("[TB] FAIL %s guard2 t=%0d observed an/seg/dp=%b/%h/%b required=%b/%h/%b",
                    tag, t, an2, seg2, dp2, e.g2[11:8], e.g2[7:1], e.g2[0]);
    endtask

    task automatic applyStimulus(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            pushExpected();
            @(posedge clk);
            #1;
            checkOutput(tag);
        end
    endtask

    task automatic pushReset();
        exp_t e;
        e.g1 = RESET_OUT;
        e.g2 = RESET_OUT;
        sb.push_back(e);
    endtask

    // Called just after a clock edge; asserts reset between edges to observe its asynchronous effect.
    task automatic resetPulse(input int edges);
        #2;
        rst = 1'b1;
        #1;
        pushReset();
        checkOutput("rst_async");
        for (int i = 0; i < edges; i++) begin
            pushReset();
            @(posedge clk);
            #1;
            checkOutput("rst_hold");
        end
        rst = 1'b0;
        t = 0;
        for (int i = 0; i < 4; i++) mdisp[i] = 4'd0;
    endtask

    initial begin
        resetPulse(2);
        applyStimulus(6, "pre_midreset");
        resetPulse(3);
        applyStimulus(FRAME, "frame1_zero");
        applyStimulus(SD + 2, "frame2_start");
        uni_segundo = 4'd8;
        applyStimulus(FRAME - SD - 2, "tear_hold");
        applyStimulus(FRAME, "tear_update");
        decimo = 4'hC;
        applyStimulus(2 * FRAME, "invalid_bcd");
        decimo = 4'd9;
        applyStimulus(2 * FRAME, "bcd_recover");
        minuto = 4'd0;
        dec_segundo = 4'd0;
        uni_segundo = 4'd5;
        decimo = 4'd3;
        applyStimulus(2 * FRAME, "min_zero");
        minuto = 4'd1;
        applyStimulus(2 * FRAME, "min_one");
        for (int f = 0; f < 6; f++) begin
            decimo      = 4'($urandom_range(0, 15));
            uni_segundo = 4'($urandom_range(0, 9));
            dec_segundo = 4'($urandom_range(0, 5));
            minuto      = 4'($urandom_range(0, 9));
            applyStimulus(5, "random");
        end
        applyStimulus(2 * FRAME, "random_tail");
        resetPulse(1);
        applyStimulus(FRAME + 3, "post_reset");
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
